// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus: run control, instruction LUT port and ALU flags.
// The err signal exists only when FETCH_WATCHDOG_EN is defined.
interface fetch_ctrl_if;
    localparam int unsigned IPTR_W = 9;
    localparam int unsigned INST_W = 20;

    logic              start;
    logic [1:0]        prog_sel;
    logic [INST_W-1:0] inst;
    logic              stall;
    logic              eq;
    logic              lt;
    logic              gt;
    logic [IPTR_W-1:0] iptr;
    logic              inst_valid;
    logic              busy;
    logic              done;
`ifdef FETCH_WATCHDOG_EN
    logic              err;

    modport master (
        input  start, prog_sel, inst, stall, eq, lt, gt,
        output iptr, inst_valid, busy, done, err
    );
    modport slave (
        output start, prog_sel, inst, stall, eq, lt, gt,
        input  iptr, inst_valid, busy, done, err
    );
`else
    modport master (
        input  start, prog_sel, inst, stall, eq, lt, gt,
        output iptr, inst_valid, busy, done
    );
    modport slave (
        output start, prog_sel, inst, stall, eq, lt, gt,
        input  iptr, inst_valid, busy, done
    );
`endif
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: walks a selected program in the LUT, resolves
// PC-relative branches and halts. Optional retire watchdog: FETCH_WATCHDOG_EN.
module fetch_ctrl #(
    parameter int unsigned WDOG_LIMIT = 4096
) (
    input  logic          clk,
    input  logic          reset,
    fetch_ctrl_if.master  bus
);
    localparam int unsigned IPTR_W = 9;
    localparam int unsigned OP_W   = 5;

    localparam logic [OP_W-1:0] OP_BE   = 5'b00111;
    localparam logic [OP_W-1:0] OP_BL   = 5'b01000;
    localparam logic [OP_W-1:0] OP_BG   = 5'b01001;
    localparam logic [OP_W-1:0] OP_BA   = 5'b01010;
    localparam logic [OP_W-1:0] OP_HALT = 5'b01110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [IPTR_W-1:0]   iptr_q, iptr_d;
    logic [IPTR_W-1:0]   end_q, end_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [OP_W-1:0]     opcode;
    logic                taken;
    logic [IPTR_W-1:0]   target;
    logic                retire;
    logic                start_acc;
    logic                wdog_hit;
    logic                inst_hi_unused;

    assign opcode    = bus.inst[19:15];
    assign retire    = (state_q == ST_RUN) && !bus.stall;
    assign start_acc = (state_q == ST_IDLE) && bus.start;
    // Low 9 bits of the sign-extended offset are all that survive truncation.
    assign target    = iptr_q + bus.inst[IPTR_W-1:0];
    assign inst_hi_unused = ^bus.inst[14:IPTR_W];

    always_comb begin
        taken = 1'b0;
        unique case (opcode)
            OP_BE:   taken = bus.eq;
            OP_BL:   taken = bus.lt;
            OP_BG:   taken = bus.gt;
            OP_BA:   taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

`ifdef FETCH_WATCHDOG_EN
    localparam int unsigned CNT_W = 16;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    assign wdog_hit = retire && ((cnt_q + CNT_W'(1)) == CNT_W'(WDOG_LIMIT));

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (start_acc) begin
            cnt_d = '0;
            err_d = 1'b0;
        end else if (retire) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (wdog_hit) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    logic wdog_limit_unused;

    assign wdog_hit          = 1'b0;
    assign wdog_limit_unused = ^WDOG_LIMIT;
`endif

    // Next state; a completing run parks iptr at zero on its way through DONE.
    always_comb begin
        state_d = state_q;
        iptr_d  = iptr_q;
        end_d   = end_q;
        unique case (state_q)
            ST_IDLE: begin
                iptr_d = '0;
                if (bus.start) begin
                    unique case (bus.prog_sel)
                        2'd0: begin state_d = ST_RUN; iptr_d = 9'h001; end_d = 9'h018; end
                        2'd1: begin state_d = ST_RUN; iptr_d = 9'h019; end_d = 9'h029; end
                        2'd2: begin state_d = ST_RUN; iptr_d = 9'h02A; end_d = 9'h03B; end
                        default: state_d = ST_DONE;
                    endcase
                end
            end
            ST_RUN: begin
                if (!bus.stall) begin
                    if (wdog_hit) begin
                        state_d = ST_DONE;
                        iptr_d  = '0;
                    end else if (taken) begin
                        iptr_d = target;
                    end else if ((opcode == OP_HALT) || (iptr_q == end_q)) begin
                        state_d = ST_DONE;
                        iptr_d  = '0;
                    end else begin
                        iptr_d = iptr_q + IPTR_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                iptr_d  = '0;
            end
            default: begin
                state_d = ST_IDLE;
                iptr_d  = '0;
            end
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            iptr_q  <= '0;
            end_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            iptr_q  <= iptr_d;
            end_q   <= end_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.iptr       = iptr_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.inst_valid = retire;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: expected retire addresses are queued when a
// run is launched and popped as the controller retires instructions.
module tb_fetch_ctrl;
    localparam int unsigned TB_WDOG = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] imem [512];
    logic        ovr_en;
    logic [19:0] ovr_val;
    logic [8:0]  sb [$];
    int          checks = 0;
    int          errors = 0;

    fetch_ctrl_if bus();

    always #5 clk = ~clk;

    assign bus.inst = ovr_en ? ovr_val : imem[bus.iptr];

    fetch_ctrl #(.WDOG_LIMIT(TB_WDOG)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b1;
        bus.prog_sel = 2'd0;
        repeat (3) @(posedge clk);
        #2;
        checks++; if (bus.iptr !== 9'h000) begin errors++; $display("FAIL reset_iptr: got %h want 000", bus.iptr); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.inst_valid); end
`ifdef FETCH_WATCHDOG_EN
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.err); end
`endif
        bus.start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Runs program sel with its branch/stall scenario, checking every retirement.
    task automatic test_program(input logic [1:0] sel);
        bit        once = 1'b0;
        bit        fin = 1'b0;
        int        stalls = 0;
        logic [8:0] exp;
        sb.delete();
        case (sel)
            2'd0: begin
                for (int a = 9'h001; a <= 9'h010; a++) sb.push_back(9'(a));
                for (int a = 9'h003; a <= 9'h018; a++) sb.push_back(9'(a));
            end
            2'd1: begin
                for (int a = 9'h019; a <= 9'h01F; a++) sb.push_back(9'(a));
                for (int a = 9'h025; a <= 9'h029; a++) sb.push_back(9'(a));
            end
            default: begin
                for (int a = 9'h02A; a <= 9'h03B; a++) sb.push_back(9'(a));
                for (int a = 9'h039; a <= 9'h03B; a++) sb.push_back(9'(a));
            end
        endcase
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.prog_sel = sel;
        for (int c = 0; c < 200 && !fin; c++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            bus.eq = (sel == 2'd1) && (bus.iptr == 9'h01F);
            bus.lt = !once && (((sel == 2'd0) && (bus.iptr == 9'h010)) ||
                               ((sel == 2'd2) && (bus.iptr == 9'h03B)));
            if (bus.lt) once = 1'b1;
            bus.stall = (sel == 2'd2) && (bus.iptr == 9'h030) && (stalls < 3);
            #1;
            if (bus.stall) begin
                stalls++;
                checks++;
                if (bus.iptr !== 9'h030 || bus.inst_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_hold: iptr %h valid %b want 030/0", bus.iptr, bus.inst_valid);
                end
            end else if (bus.inst_valid) begin
                exp = 9'h1FF;
                if (sb.size() > 0) exp = sb.pop_front();
                checks++;
                if (bus.iptr !== exp || bus.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL prog%0d_retire: iptr %h busy %b want %h/1", sel, bus.iptr, bus.busy, exp);
                end
            end
            if (bus.done) begin
                fin = 1'b1;
                checks++;
                if (sb.size() != 0 || bus.iptr !== 9'h000 || bus.busy !== 1'b0) begin
                    errors++;
                    $display("FAIL prog%0d_done: left %0d iptr %h busy %b want 0/000/0", sel, sb.size(), bus.iptr, bus.busy);
                end
            end
        end
        checks++; if (!fin) begin errors++; $display("FAIL prog%0d_timeout: done not seen, want done", sel); end
        @(posedge clk); #2;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.iptr !== 9'h000) begin
            errors++;
            $display("FAIL prog%0d_idle: done %b busy %b iptr %h want 0/0/000", sel, bus.done, bus.busy, bus.iptr);
        end
        if (sel == 2'd2) begin
            checks++; if (stalls != 3) begin errors++; $display("FAIL stall_count: got %0d want 3", stalls); end
        end
        bus.eq = 1'b0; bus.lt = 1'b0; bus.stall = 1'b0;
    endtask

    // Injected halt, ignored start during RUN, then the reserved program.
    task automatic test_halt();
        bit         fin = 1'b0;
        logic [8:0] exp;
        sb.delete();
        for (int a = 1; a <= 5; a++) sb.push_back(9'(a));
        ovr_val = 20'h70000;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.prog_sel = 2'd0;
        for (int c = 0; c < 50 && !fin; c++) begin
            @(posedge clk); #1;
            bus.start = (bus.iptr == 9'h003);
            bus.prog_sel = (bus.iptr == 9'h003) ? 2'd3 : 2'd0;
            ovr_en = (bus.iptr == 9'h005);
            #1;
            if (bus.inst_valid) begin
                exp = 9'h1FF;
                if (sb.size() > 0) exp = sb.pop_front();
                checks++;
                if (bus.iptr !== exp) begin errors++; $display("FAIL halt_retire: iptr %h want %h", bus.iptr, exp); end
            end
            if (bus.done) begin
                fin = 1'b1;
                checks++;
                if (sb.size() != 0) begin errors++; $display("FAIL halt_done: %0d retirements left want 0", sb.size()); end
            end
        end
        checks++; if (!fin) begin errors++; $display("FAIL halt_timeout: done not seen, want done"); end
        ovr_en = 1'b0;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.prog_sel = 2'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        #1;
        checks++;
        if (bus.done !== 1'b1 || bus.inst_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL sel3_done: done %b valid %b busy %b want 1/0/0", bus.done, bus.inst_valid, bus.busy);
        end
        @(posedge clk); #2;
        checks++;
        if (bus.done !== 1'b0 || bus.inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL sel3_idle: done %b valid %b want 0/0", bus.done, bus.inst_valid);
        end
        bus.prog_sel = 2'd0;
    endtask

    task automatic test_reset_mid();
        bit         hit = 1'b0;
        logic [8:0] exp;
        sb.delete();
        for (int a = 1; a <= 9; a++) sb.push_back(9'(a));
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.prog_sel = 2'd0;
        for (int c = 0; c < 50 && !hit; c++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (bus.iptr == 9'h00A) begin reset = 1'b1; hit = 1'b1; end
            #1;
            if (!reset && bus.inst_valid) begin
                exp = 9'h1FF;
                if (sb.size() > 0) exp = sb.pop_front();
                checks++;
                if (bus.iptr !== exp) begin errors++; $display("FAIL rstmid_retire: iptr %h want %h", bus.iptr, exp); end
            end
        end
        checks++; if (!hit || sb.size() != 0) begin errors++; $display("FAIL rstmid_reach: hit %b left %0d want 1/0", hit, sb.size()); end
        bus.start = 1'b1;
        bus.stall = 1'b1;
        @(posedge clk); #2;
        checks++;
        if (bus.iptr !== 9'h000 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_idle: iptr %h busy %b done %b valid %b want 000/0/0/0", bus.iptr, bus.busy, bus.done, bus.inst_valid);
        end
        bus.start = 1'b0;
        bus.stall = 1'b0;
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #2;
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_nodone: done %b busy %b want 0/0", bus.done, bus.busy);
            end
        end
    endtask

`ifdef FETCH_WATCHDOG_EN
    task automatic test_watchdog();
        bit         fin = 1'b0;
        logic [8:0] exp;
        sb.delete();
        for (int a = 0; a < int'(TB_WDOG); a++) sb.push_back(9'h001);
        ovr_val = 20'h50000;
        ovr_en = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.prog_sel = 2'd0;
        for (int c = 0; c < 50 && !fin; c++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            #1;
            if (bus.inst_valid) begin
                exp = 9'h1FF;
                if (sb.size() > 0) exp = sb.pop_front();
                checks++;
                if (bus.iptr !== exp) begin errors++; $display("FAIL wdog_retire: iptr %h want %h", bus.iptr, exp); end
            end
            if (bus.done) begin
                fin = 1'b1;
                checks++;
                if (sb.size() != 0 || bus.err !== 1'b1) begin
                    errors++;
                    $display("FAIL wdog_done: left %0d err %b want 0/1", sb.size(), bus.err);
                end
            end
        end
        checks++; if (!fin) begin errors++; $display("FAIL wdog_timeout: done not seen, want done"); end
        ovr_en = 1'b0;
        @(posedge clk); #2;
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL wdog_sticky: err %b want 1", bus.err); end
        bus.start = 1'b1;
        bus.prog_sel = 2'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        #1;
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL wdog_clear: err %b want 0", bus.err); end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        foreach (imem[i]) imem[i] = 20'h00000;
        imem[9'h010] = {5'b01000, 15'h7FF3};
        imem[9'h01F] = {5'b00111, 15'h0006};
        imem[9'h027] = {5'b01001, 15'h7FFB};
        imem[9'h03B] = {5'b01000, 15'h7FFE};
        ovr_en = 1'b0;
        ovr_val = 20'h00000;
        bus.start = 1'b0;
        bus.prog_sel = 2'd0;
        bus.stall = 1'b0;
        bus.eq = 1'b0;
        bus.lt = 1'b0;
        bus.gt = 1'b0;
        test_reset();
`ifndef FETCH_WATCHDOG_EN
        test_program(2'd0);
        test_program(2'd1);
        test_program(2'd2);
`endif
        test_halt();
`ifndef FETCH_WATCHDOG_EN
        test_reset_mid();
`else
        test_watchdog();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter WDOG_LIMIT, 4096: maximum retired instructions per run; used only when FETCH_WATCHDOG_EN is defined.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  run request; sampled only in IDLE.
REQ-005 prog_sel  input  2  program select: 0 product, 1 string match, 2 closest pair, 3 reserved.
REQ-006 inst  input  20  instruction word returned combinationally by the instruction LUT for the current iptr.
REQ-007 stall  input  1  holds iptr and all state for the cycle.
REQ-008 eq, lt, gt  input  1 each  ALU compare flags, valid in the cycle a branch is presented on inst.
REQ-009 iptr  output  9  instruction pointer driven to the LUT.
REQ-010 inst_valid  output  1  inst is retired this cycle; high iff state RUN and !stall.
REQ-011 busy  output  1  high in RUN.
REQ-012 done  output  1  one-cycle pulse when a run completes.
REQ-013 err  output  1  watchdog abort flag; exists only when FETCH_WATCHDOG_EN is defined.

Function
REQ-014 States: IDLE, RUN, DONE; encoding is free.
REQ-015 IDLE: iptr = 0x000; busy = 0; done = 0.
REQ-016 IDLE with start=1 and prog_sel 0/1/2: next cycle state RUN, iptr = 0x001 / 0x019 / 0x02A respectively; the end address is latched as 0x018 / 0x029 / 0x03B.
REQ-017 IDLE with start=1 and prog_sel=3: go directly to DONE with no retirement.
REQ-018 start outside IDLE is ignored; prog_sel is sampled only with an accepted start.
REQ-019 Opcode is inst[19:15]. Branches: 00111 be (taken if eq), 01000 bl (taken if lt), 01001 bg (taken if gt), 01010 ba (always taken). Halt: 01110.
REQ-020 Taken-branch target = iptr + sign-extended inst[14:0], truncated to 9 bits; PC-relative to the branch's own address. Wraps modulo 512.
REQ-021 RUN, !stall, per-cycle priority: (1) taken branch -> iptr = target; (2) halt opcode or iptr == end address -> state DONE; (3) otherwise iptr += 1, wrapping 0x1FF -> 0x000.
REQ-022 A taken branch located at the end address branches and does not complete the run.
REQ-023 RUN with stall=1: iptr, state and counters hold; inst_valid = 0; flags are ignored.
REQ-024 DONE: done = 1 for exactly one cycle, busy = 0, iptr = 0x000; the next state is IDLE unconditionally.
REQ-025 Latency: start accepted at edge N; first instruction presented at N+1; done is observed one cycle after the completing instruction retires.

Reset
REQ-026 reset=1 at an edge forces IDLE. It also forces iptr=0x000, busy=0, done=0, inst_valid=0, err=0, the end address to 0x000 and the retire counter to 0.
REQ-027 Reset asserted mid-run aborts the run with no done pulse; reset dominates start and stall.

Configuration
REQ-028 Macro FETCH_WATCHDOG_EN defined: a 16-bit retire counter clears on an accepted start and increments on each inst_valid.
REQ-029 With FETCH_WATCHDOG_EN, a retirement that makes the count equal WDOG_LIMIT forces DONE (done pulse) and sets err; err stays sticky until the next accepted start or reset.
REQ-030 FETCH_WATCHDOG_EN undefined: no counter and no err port; runs are unbounded.

Verification
REQ-031 Reset, then start with prog_sel=0 and stall=0. Required: iptr 0x001,0x002,...; at iptr=0x010 (bl) with lt=1, the next iptr = 0x003.
REQ-032 prog_sel=1, walk to 0x01F (be) with eq=1. Required: next iptr 0x025; with no further taken branches, iptr reaches 0x029, done pulses once at 0x029+1 cycle, then IDLE.
REQ-033 prog_sel=2 with stall=1 for 3 cycles at iptr 0x030. Required: iptr holds at 0x030 and inst_valid=0 for 3 cycles, then resumes at 0x031.
REQ-034 Inject inst = 0x70000 (halt) mid-run. Required: done next cycle; start pulsed during RUN is ignored; prog_sel=3 gives a done pulse with zero retirements.
REQ-035 reset asserted at iptr 0x00A during RUN. Required: next cycle IDLE, iptr 0x000, no done pulse.
REQ-036 FETCH_WATCHDOG_EN, WDOG_LIMIT=8, ba with offset 0 presented continuously. Required: done and err rise after the 8th retirement; err clears on the next accepted start.
